// File: rtl/hpi_sequencer.sv
// HPI bus sequencer: arbitrates two requesters round-robin and runs one
// chip-select/strobe/hold/recover access at a time, after a timed HPI reset.

module hpi_sequencer_checker (
  input logic clk_i,
  input logic rst_i,
  input logic cs_n_i,
  input logic r_n_i,
  input logic w_n_i,
  input logic oe_i,
  input logic ack0_i,
  input logic ack1_i
);

  a_strobe_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(!r_n_i && !w_n_i));

  a_strobe_in_cs: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_n_i && w_n_i) || !cs_n_i);

  a_oe_not_read: assert property (@(posedge clk_i) disable iff (rst_i)
    !(oe_i && !r_n_i));

  a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ack0_i && ack1_i));

endmodule

module hpi_sequencer #(
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned RESET_CYCLES   = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ack,
  output logic        req0_done,
  output logic [15:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ack,
  output logic        req1_done,
  output logic [15:0] req1_rdata,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs,
  output logic        otg_hpi_r,
  output logic        otg_hpi_w,
  output logic        otg_hpi_reset,
  input  logic [15:0] otg_hpi_data_in,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  output logic        init_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_CYCLES - 1);
  localparam logic [7:0] RESET_LAST   = 8'(RESET_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic [1:0]  hpi_addr_q, hpi_addr_d;
  logic [15:0] dout_q, dout_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        oe_q, oe_d;
  logic        hpi_rst_n_q, hpi_rst_n_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  logic        grant_any_s;
  logic        grant_idx_s;
  logic        ack_s;
  logic        capture_s;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    grant_idx_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_idx_s = ~last_q;
    end else if (req1_valid) begin
      grant_idx_s = 1'b1;
    end else begin
      grant_idx_s = 1'b0;
    end
  end

  assign grant_any_s = req0_valid | req1_valid;
  assign ack_s       = (state_q == ST_IDLE) && grant_any_s;
  assign req0_ack    = ack_s && !grant_idx_s;
  assign req1_ack    = ack_s && grant_idx_s;
  assign capture_s   = (state_q == ST_STROBE) && (cnt_q == STROBE_LAST) && !wr_q;

  // Next-state, phase counter and latched request fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == RESET_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d = ST_SETUP;
          cnt_d   = 8'd0;
          last_d  = grant_idx_s;
          wr_d    = grant_idx_s ? req1_write : req0_write;
          addr_d  = grant_idx_s ? req1_addr  : req0_addr;
          wdata_d = grant_idx_s ? req1_wdata : req0_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = 8'd0;
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_RECOVER;
        cnt_d   = 8'd0;
      end
      ST_RECOVER: begin
        if (cnt_q == RECOVER_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // HPI pin values decoded from the state being entered, so every pin is a flop.
  always_comb begin
    hpi_addr_d  = hpi_addr_q;
    dout_d      = dout_q;
    cs_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    oe_d        = 1'b0;
    hpi_rst_n_d = 1'b1;
    init_done_d = 1'b1;
    busy_d      = 1'b1;
    case (state_d)
      ST_INIT: begin
        hpi_addr_d  = 2'd0;
        dout_d      = 16'd0;
        hpi_rst_n_d = 1'b0;
        init_done_d = 1'b0;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        cs_n_d     = 1'b0;
        hpi_addr_d = addr_d;
        if (wr_d) begin
          dout_d = wdata_d;
          oe_d   = 1'b1;
        end else begin
          dout_d = dout_q;
          oe_d   = 1'b0;
        end
        if (state_d == ST_STROBE) begin
          rd_n_d = wr_d;
          wr_n_d = ~wr_d;
        end else begin
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
        end
      end
      ST_RECOVER: begin
        cs_n_d = 1'b1;
      end
      default: begin
        hpi_rst_n_d = 1'b0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Completion pulse and read-data capture for the granted requester.
  always_comb begin
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (state_d == ST_HOLD) begin
      done0_d = ~last_d;
      done1_d = last_d;
    end else begin
      done0_d = 1'b0;
      done1_d = 1'b0;
    end
    if (capture_s) begin
      if (last_q) begin
        rdata1_d = otg_hpi_data_in;
      end else begin
        rdata0_d = otg_hpi_data_in;
      end
    end else begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'd0;
      last_q      <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 16'd0;
      hpi_addr_q  <= 2'd0;
      dout_q      <= 16'd0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      hpi_rst_n_q <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= 16'd0;
      rdata1_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hpi_addr_q  <= hpi_addr_d;
      dout_q      <= dout_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      oe_q        <= oe_d;
      hpi_rst_n_q <= hpi_rst_n_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign otg_hpi_address  = hpi_addr_q;
  assign otg_hpi_cs       = cs_n_q;
  assign otg_hpi_r        = rd_n_q;
  assign otg_hpi_w        = wr_n_q;
  assign otg_hpi_reset    = hpi_rst_n_q;
  assign otg_hpi_data_out = dout_q;
  assign otg_hpi_data_oe  = oe_q;
  assign init_done        = init_done_q;
  assign busy             = busy_q;
  assign req0_done        = done0_q;
  assign req1_done        = done1_q;
  assign req0_rdata       = rdata0_q;
  assign req1_rdata       = rdata1_q;

  hpi_sequencer_checker u_checker (
    .clk_i  (clk_clk),
    .rst_i  (reset_reset),
    .cs_n_i (cs_n_q),
    .r_n_i  (rd_n_q),
    .w_n_i  (wr_n_q),
    .oe_i   (oe_q),
    .ack0_i (req0_ack),
    .ack1_i (req1_ack)
  );

endmodule

// File: tb/tb_hpi_sequencer.sv
// Directed bench for hpi_sequencer: default-timing instance plus a 1/1-cycle instance,
// completions checked against a scoreboard of expected results.

module tb_hpi_sequencer;

  localparam int S1 = 4;
  localparam int R1 = 2;
  localparam int S2 = 1;

  logic clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  logic        reset_reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [1:0]  req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ack, req0_done, req1_ack, req1_done;
  logic [15:0] req0_rdata, req1_rdata;
  logic [1:0]  otg_hpi_address;
  logic        otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset, otg_hpi_data_oe;
  logic [15:0] otg_hpi_data_in, otg_hpi_data_out;
  logic        init_done, busy;

  logic        d2_reset;
  logic        d2_req0_valid, d2_req0_write, d2_req1_valid, d2_req1_write;
  logic [1:0]  d2_req0_addr, d2_req1_addr;
  logic [15:0] d2_req0_wdata, d2_req1_wdata;
  logic        d2_req0_ack, d2_req0_done, d2_req1_ack, d2_req1_done;
  logic [15:0] d2_req0_rdata, d2_req1_rdata;
  logic [1:0]  d2_address;
  logic        d2_cs, d2_r, d2_w, d2_hpi_reset, d2_oe;
  logic [15:0] d2_data_in, d2_data_out;
  logic        d2_init_done, d2_busy;

  hpi_sequencer dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .otg_hpi_address(otg_hpi_address), .otg_hpi_cs(otg_hpi_cs),
    .otg_hpi_r(otg_hpi_r), .otg_hpi_w(otg_hpi_w), .otg_hpi_reset(otg_hpi_reset),
    .otg_hpi_data_in(otg_hpi_data_in), .otg_hpi_data_out(otg_hpi_data_out),
    .otg_hpi_data_oe(otg_hpi_data_oe), .init_done(init_done), .busy(busy)
  );

  hpi_sequencer #(.STROBE_CYCLES(1), .RECOVER_CYCLES(1)) dut2 (
    .clk_clk(clk_clk), .reset_reset(d2_reset),
    .req0_valid(d2_req0_valid), .req0_write(d2_req0_write), .req0_addr(d2_req0_addr),
    .req0_wdata(d2_req0_wdata), .req0_ack(d2_req0_ack), .req0_done(d2_req0_done),
    .req0_rdata(d2_req0_rdata),
    .req1_valid(d2_req1_valid), .req1_write(d2_req1_write), .req1_addr(d2_req1_addr),
    .req1_wdata(d2_req1_wdata), .req1_ack(d2_req1_ack), .req1_done(d2_req1_done),
    .req1_rdata(d2_req1_rdata),
    .otg_hpi_address(d2_address), .otg_hpi_cs(d2_cs),
    .otg_hpi_r(d2_r), .otg_hpi_w(d2_w), .otg_hpi_reset(d2_hpi_reset),
    .otg_hpi_data_in(d2_data_in), .otg_hpi_data_out(d2_data_out),
    .otg_hpi_data_oe(d2_oe), .init_done(d2_init_done), .busy(d2_busy)
  );

  typedef struct {
    int          idx;
    bit          rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ack_cyc1[2];
  int   ack_cnt1[2];
  int   done_cnt1 = 0;
  int   ack_cyc2[2];

  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pin-protocol monitor for the default instance.
  always @(negedge clk_clk) begin : mon1
    exp_t e;
    if (req0_ack) begin ack_cyc1[0] = cyc; ack_cnt1[0]++; end
    if (req1_ack) begin ack_cyc1[1] = cyc; ack_cnt1[1]++; end
    if (cyc > 0)
      chk("dut1_protocol", {31'd0, (!otg_hpi_r && !otg_hpi_w) ||
          ((!otg_hpi_r || !otg_hpi_w) && otg_hpi_cs) || (otg_hpi_data_oe && !otg_hpi_r)}, 32'd0);
    if (req0_done || req1_done) begin
      done_cnt1++;
      if (sb1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb1.pop_front();
        chk("dut1_done_idx", {31'd0, req1_done}, e.idx);
        chk("dut1_done_latency", cyc - ack_cyc1[e.idx], 2 + S1);
        if (e.rd) chk("dut1_rdata", e.idx == 1 ? req1_rdata : req0_rdata, {16'd0, e.rdata});
      end
    end
  end

  // Scoreboard and pin-protocol monitor for the short-timing instance.
  always @(negedge clk_clk) begin : mon2
    exp_t e;
    if (d2_req0_ack) ack_cyc2[0] = cyc;
    if (d2_req1_ack) ack_cyc2[1] = cyc;
    if (cyc > 0)
      chk("dut2_protocol", {31'd0, (!d2_r && !d2_w) || ((!d2_r || !d2_w) && d2_cs) || (d2_oe && !d2_r)}, 32'd0);
    if (d2_req0_done || d2_req1_done) begin
      if (sb2.size() == 0) begin
        chk("dut2_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb2.pop_front();
        chk("dut2_done_idx", {31'd0, d2_req1_done}, e.idx);
        chk("dut2_done_latency", cyc - ack_cyc2[e.idx], 2 + S2);
        if (e.rd) chk("dut2_rdata", e.idx == 1 ? d2_req1_rdata : d2_req0_rdata, {16'd0, e.rdata});
      end
    end
  end

  task automatic push1(input int idx, input bit rd, input logic [15:0] rdata);
    exp_t e;
    e.idx = idx; e.rd = rd; e.rdata = rdata;
    sb1.push_back(e);
  endtask

  task automatic wait_ack(input int idx, input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_clk);
      if (idx == 0 ? req0_ack : req1_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Called at the ack cycle: drops/scrambles requests, then profiles the whole access.
  task automatic observe(input bit wr, input logic [1:0] addr, input logic [15:0] wdata,
                         input string tag);
    int cs_low = 0, r_low = 0, w_low = 0, oe_hi = 0, addr_ok = 0, data_ok = 0;
    @(posedge clk_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_write = ~req0_write; req1_write = ~req1_write;
    req0_addr = ~req0_addr; req1_addr = ~req1_addr;
    req0_wdata = ~req0_wdata; req1_wdata = ~req1_wdata;
    repeat (S1 + R1 + 2) begin
      @(negedge clk_clk);
      if (!otg_hpi_cs) begin
        cs_low++;
        if (otg_hpi_address == addr) addr_ok++;
      end
      if (!otg_hpi_r) r_low++;
      if (!otg_hpi_w) begin
        w_low++;
        if (otg_hpi_data_out == wdata) data_ok++;
      end
      if (otg_hpi_data_oe) oe_hi++;
    end
    chk({tag, "_cs_low_cycles"}, cs_low, S1 + 2);
    chk({tag, "_addr_cycles"}, addr_ok, S1 + 2);
    chk({tag, "_r_low_cycles"}, r_low, wr ? 0 : S1);
    chk({tag, "_w_low_cycles"}, w_low, wr ? S1 : 0);
    chk({tag, "_wdata_cycles"}, data_ok, wr ? S1 : 0);
    chk({tag, "_oe_cycles"}, oe_hi, wr ? S1 + 2 : 0);
    chk({tag, "_sb_drained"}, sb1.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int low, gi[4], gc[4], got, base, dc;
    exp_t e2;
    reset_reset = 1'b1; d2_reset = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 2'd0; req0_wdata = 16'd0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 16'd0;
    otg_hpi_data_in = 16'd0;
    d2_req0_valid = 1'b0; d2_req0_write = 1'b0; d2_req0_addr = 2'd0; d2_req0_wdata = 16'd0;
    d2_req1_valid = 1'b0; d2_req1_write = 1'b0; d2_req1_addr = 2'd0; d2_req1_wdata = 16'd0;
    d2_data_in = 16'd0;

    // Reset values.
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("rst_cs", otg_hpi_cs, 1); chk("rst_r", otg_hpi_r, 1); chk("rst_w", otg_hpi_w, 1);
    chk("rst_hpi_reset", otg_hpi_reset, 0); chk("rst_addr", otg_hpi_address, 0);
    chk("rst_dout", otg_hpi_data_out, 0); chk("rst_oe", otg_hpi_data_oe, 0);
    chk("rst_init_done", init_done, 0); chk("rst_busy", busy, 1);
    chk("rst_done", {req0_done, req1_done}, 0); chk("rst_rdata0", req0_rdata, 0);
    chk("rst_rdata1", req1_rdata, 0);

    // Release reset with a write already pending from req0.
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd2; req0_wdata = 16'h1234;
    push1(0, 1'b0, 16'h0000);
    low = 0; base = ack_cnt1[0];
    repeat (16) begin
      @(negedge clk_clk);
      if (!otg_hpi_reset && !init_done) low++;
    end
    chk("init_low_cycles", low, 16);
    chk("init_no_ack", ack_cnt1[0] - base, 0);
    @(negedge clk_clk);
    chk("init_done_17", init_done, 1); chk("init_busy_17", busy, 0);
    chk("init_hpi_reset_17", otg_hpi_reset, 1); chk("init_first_ack", req0_ack, 1);
    observe(1'b1, 2'd2, 16'h1234, "wr0");

    // Read from req1.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd0; otg_hpi_data_in = 16'hBEEF;
    push1(1, 1'b1, 16'hBEEF);
    wait_ack(1, 6, "rd1");
    observe(1'b0, 2'd0, 16'h0000, "rd1");
    chk("rd1_rdata_held", req1_rdata, 16'hBEEF);

    // Both requesters valid continuously: alternating grants.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd1; req0_wdata = 16'hA5A5;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd3; otg_hpi_data_in = 16'hC3C3;
    push1(0, 1'b0, 16'h0); push1(1, 1'b1, 16'hC3C3);
    push1(0, 1'b0, 16'h0); push1(1, 1'b1, 16'hC3C3);
    got = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      @(negedge clk_clk);
      if (req0_ack || req1_ack) begin
        gi[got] = req1_ack ? 1 : 0;
        gc[got] = cyc;
        got++;
      end
    end
    @(posedge clk_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_ack_count", got, 4);
    for (int k = 0; k < 4; k++) chk("rr_grant_order", gi[k], k % 2);
    for (int k = 1; k < 4; k++) chk("rr_ack_spacing", gc[k] - gc[k-1], 9);
    for (int i = 0; i < 40 && sb1.size() != 0; i++) @(negedge clk_clk);
    chk("rr_sb_drained", sb1.size(), 0);

    // Read with fields changed after ack; a req1 pulse while busy must be dropped.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd1; otg_hpi_data_in = 16'h0F0F;
    push1(0, 1'b1, 16'h0F0F);
    wait_ack(0, 12, "rd0");
    base = ack_cnt1[1];
    @(posedge clk_clk); #1;
    req0_valid = 1'b0; req0_write = 1'b1; req0_addr = 2'd2; req1_valid = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1 req1_valid = 1'b0;
    repeat (12) @(negedge clk_clk);
    chk("drop_req1_no_ack", ack_cnt1[1] - base, 0);
    chk("rd0_sb_drained", sb1.size(), 0);
    chk("rd0_rdata", req0_rdata, 16'h0F0F);

    // Reset pulsed during the strobe of a write.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd3; req0_wdata = 16'h5555;
    push1(0, 1'b0, 16'h0);
    wait_ack(0, 12, "abort");
    dc = done_cnt1;
    @(posedge clk_clk); #1;
    req0_valid = 1'b0;
    @(negedge clk_clk);
    @(negedge clk_clk);
    chk("abort_w_low_in_strobe", otg_hpi_w, 0);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    chk("abort_w_high", otg_hpi_w, 1); chk("abort_cs_high", otg_hpi_cs, 1);
    chk("abort_init_done", init_done, 0);
    reset_reset = 1'b0;
    low = otg_hpi_reset ? 0 : 1;
    repeat (15) begin
      @(negedge clk_clk);
      if (!otg_hpi_reset) low++;
    end
    @(negedge clk_clk);
    chk("abort_reset_low_cycles", low, 16);
    chk("abort_hpi_reset_release", otg_hpi_reset, 1);
    chk("abort_no_done", done_cnt1 - dc, 0);
    sb1.delete();

    // Short-timing instance: back-to-back reads from one requester.
    @(posedge clk_clk); #1;
    d2_reset = 1'b0;
    for (int i = 0; i < 40 && d2_init_done !== 1'b1; i++) @(negedge clk_clk);
    chk("d2_init_done", d2_init_done, 1);
    d2_data_in = 16'h1111;
    d2_req0_valid = 1'b1; d2_req0_write = 1'b0; d2_req0_addr = 2'd1;
    e2.idx = 0; e2.rd = 1'b1; e2.rdata = 16'h1111; sb2.push_back(e2);
    e2.rdata = 16'h2222; sb2.push_back(e2);
    got = 0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      @(negedge clk_clk);
      if (d2_req0_done) d2_data_in = 16'h2222;
      if (d2_req0_ack) begin
        gc[got] = cyc;
        got++;
      end
    end
    @(posedge clk_clk); #1;
    d2_req0_valid = 1'b0;
    chk("d2_ack_count", got, 2);
    chk("d2_ack_spacing", gc[1] - gc[0], 5);
    for (int i = 0; i < 20 && sb2.size() != 0; i++) @(negedge clk_clk);
    chk("d2_sb_drained", sb2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hpi_sequencer.md
HPI_SEQUENCER -- requirements
Module: hpi_sequencer

Interface
REQ-001 Parameter STROBE_CYCLES, default 4: cycles the r/w strobe is held asserted (legal 1..15).
REQ-002 Parameter RECOVER_CYCLES, default 2: cycles cs is held deasserted between accesses (legal 1..15).
REQ-003 Parameter RESET_CYCLES, default 16: cycles the HPI reset is held asserted after block reset (legal 1..255).
REQ-004 clk_clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset_reset  in  1  synchronous, active-high reset.
REQ-006 reqN_valid  in  1  (N=0,1) requester N has an access pending; held until acked.
REQ-007 reqN_write  in  1  1=write, 0=read.
REQ-008 reqN_addr  in  2  HPI register select.
REQ-009 reqN_wdata  in  16  write data.
REQ-010 reqN_ack  out  1  one-cycle pulse; request fields sampled this cycle.
REQ-011 reqN_done  out  1  one-cycle pulse; access complete, reqN_rdata valid.
REQ-012 reqN_rdata  out  16  read data, held until that requester's next done.
REQ-013 otg_hpi_address  out  2  HPI address.
REQ-014 otg_hpi_cs  out  1  chip select, active-low.
REQ-015 otg_hpi_r  out  1  read strobe, active-low.
REQ-016 otg_hpi_w  out  1  write strobe, active-low.
REQ-017 otg_hpi_reset  out  1  HPI device reset, active-low.
REQ-018 otg_hpi_data_in  in  16  HPI read data.
REQ-019 otg_hpi_data_out  out  16  HPI write data.
REQ-020 otg_hpi_data_oe  out  1  1 = top level drives data_out onto the HPI bus.
REQ-021 init_done  out  1  HPI reset sequence finished; requests are serviced.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 States: INIT, IDLE, SETUP, STROBE, HOLD, RECOVER; all HPI outputs registered.
REQ-024 INIT: otg_hpi_reset=0 for exactly RESET_CYCLES cycles, then IDLE with otg_hpi_reset=1 and init_done=1 from the first IDLE cycle onward.
REQ-025 No ack is issued in INIT regardless of reqN_valid.
REQ-026 IDLE, any valid: grant one requester, pulse its ack, latch write/addr/wdata and the granted index, go to SETUP.
REQ-027 Arbitration round-robin: a sole valid requester wins; if both are valid, the one not granted last wins; the last-grant register resets to 1, so req0 wins the first tie.
REQ-028 SETUP (1 cycle): cs=0, address driven; for writes data_out=wdata and data_oe=1; r=w=1.
REQ-029 STROBE (STROBE_CYCLES cycles): r=0 (read) or w=0 (write); cs, address, data and oe held.
REQ-030 Read data: otg_hpi_data_in is captured into the granted reqN_rdata on the last STROBE cycle.
REQ-031 HOLD (1 cycle): r=w=1, cs=0, address/data/oe held; the granted reqN_done pulses.
REQ-032 RECOVER (RECOVER_CYCLES cycles): cs=1, data_oe=0; then IDLE.
REQ-033 Latency: done is asserted 2+STROBE_CYCLES cycles after ack; minimum ack-to-ack spacing is 3+STROBE_CYCLES+RECOVER_CYCLES cycles (9 at defaults).
REQ-034 r and w are never low simultaneously; a strobe is low only while cs=0.
REQ-035 data_oe is never 1 during a read access.
REQ-036 Request inputs changing after ack do not affect the access in flight.
REQ-037 Valid deasserted before ack: the request is dropped without side effect.

Reset
REQ-038 On reset_reset=1 at an edge: state=INIT, cycle counter=0, cs=r=w=1, otg_hpi_reset=0, address=0, data_out=0, data_oe=0, acks/dones=0, rdata=0, init_done=0, busy=1, last-grant=1.
REQ-039 Reset mid-access aborts it at that edge: strobes and cs deassert, no done is issued, and the INIT sequence restarts.

Verification
REQ-040 Release reset -> otg_hpi_reset low for 16 cycles; init_done=1 and busy=0 on the 17th cycle; req0_valid held during INIT gets no ack.
REQ-041 req0 write addr=2 wdata=0x1234 -> cs low 6 cycles, w low 4 cycles with data_out=0x1234 and oe=1 throughout, r stays 1, req0_done 6 cycles after ack.
REQ-042 req1 read addr=0 with data_in=0xBEEF -> r low 4 cycles, req1_rdata=0xBEEF at req1_done, data_oe=0 throughout.
REQ-043 req0 and req1 valid in the same cycle, continuously -> grants alternate 0,1,0,1; acks spaced 9 cycles apart.
REQ-044 reset_reset pulsed during STROBE of a write -> w and cs high on the next cycle, no done, otg_hpi_reset low again for 16 cycles.
REQ-045 STROBE_CYCLES=1, RECOVER_CYCLES=1 -> back-to-back reads acked 5 cycles apart, each rdata correct.
